// File: rtl/iq_pkg.sv
// Shared types and default widths for the age-ordered issue queue.
// Operands carry their own ready bit, producer tag and captured value.
package iq_pkg;

  localparam int IQ_TAG_W     = 6;
  localparam int IQ_DATA_W    = 32;
  localparam int IQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic                 rdy;
    logic [IQ_TAG_W-1:0]  tag;
    logic [IQ_DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    operand_t                src1;
    operand_t                src2;
    logic [IQ_TAG_W-1:0]     dst_tag;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/iq_oldest_select.sv
// Picks up to ISSUE_PORTS set bits of a candidate vector, lowest index first.
// Each port's grant is masked out before the next port searches.
module iq_oldest_select #(
  parameter int DEPTH       = 8,
  parameter int ISSUE_PORTS = 2
) (
  input  logic [DEPTH-1:0]                            cand,
  output logic [ISSUE_PORTS-1:0]                      grant_valid,
  output logic [ISSUE_PORTS-1:0][$clog2(DEPTH)-1:0]   grant_idx,
  output logic [ISSUE_PORTS-1:0][DEPTH-1:0]           grant_oh
);

  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    logic [DEPTH-1:0] remaining;
    remaining = cand;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      grant_valid[p] = 1'b0;
      grant_idx[p]   = '0;
      grant_oh[p]    = '0;
      // Descending scan so the lowest remaining index is the last one written.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (remaining[i]) begin
          grant_valid[p] = 1'b1;
          grant_idx[p]   = IDX_W'(i);
        end
      end
      if (grant_valid[p]) begin
        grant_oh[p][grant_idx[p]] = 1'b1;
      end
      remaining = remaining & ~grant_oh[p];
    end
  end

endmodule

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: slot 0 is oldest, survivors compact downward each
// cycle, new dispatches append behind them, and wake buses fill operands.
module age_issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WRITE_PORTS = 2,
  parameter int ISSUE_PORTS = 2,
  parameter int WAKE_PORTS  = 4,
  parameter int TAG_W       = IQ_TAG_W,
  parameter int DATA_W      = IQ_DATA_W,
  parameter int PAYLOAD_W   = IQ_PAYLOAD_W,
  parameter int IN_ORDER    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [WRITE_PORTS-1:0]                 in_valid,
  input  iq_entry_t [WRITE_PORTS-1:0]            in_entry,
  output logic                                   in_ready,
  input  logic [WAKE_PORTS-1:0]                  wake_valid,
  input  logic [WAKE_PORTS-1:0][TAG_W-1:0]       wake_tag,
  input  logic [WAKE_PORTS-1:0][DATA_W-1:0]      wake_data,
  output logic [ISSUE_PORTS-1:0]                 issue_valid,
  output iq_entry_t [ISSUE_PORTS-1:0]            issue_entry,
  input  logic [ISSUE_PORTS-1:0]                 issue_ready,
  input  logic                                   hold,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  iq_entry_t                           entries_q [DEPTH];
  iq_entry_t                           entries_d [DEPTH];
  logic [CNT_W-1:0]                    count_q;
  logic [CNT_W-1:0]                    count_d;
  logic [DEPTH-1:0]                    cand;
  logic [DEPTH-1:0]                    leave;
  logic [ISSUE_PORTS-1:0]              grant_valid;
  logic [ISSUE_PORTS-1:0][IDX_W-1:0]   grant_idx;
  logic [ISSUE_PORTS-1:0][DEPTH-1:0]   grant_oh;

  // Lowest matching bus wins, so scan downward and let later hits overwrite.
  function automatic operand_t wake_op(
    input operand_t                              op,
    input logic [WAKE_PORTS-1:0]                 wv,
    input logic [WAKE_PORTS-1:0][TAG_W-1:0]      wt,
    input logic [WAKE_PORTS-1:0][DATA_W-1:0]     wd
  );
    operand_t res;
    res = op;
    if (!op.rdy) begin
      for (int k = WAKE_PORTS - 1; k >= 0; k--) begin
        if (wv[k] && (wt[k] == op.tag)) begin
          res.rdy  = 1'b1;
          res.data = wd[k];
        end
      end
    end
    return res;
  endfunction

  function automatic iq_entry_t wake_entry(
    input iq_entry_t                             e,
    input logic [WAKE_PORTS-1:0]                 wv,
    input logic [WAKE_PORTS-1:0][TAG_W-1:0]      wt,
    input logic [WAKE_PORTS-1:0][DATA_W-1:0]     wd
  );
    iq_entry_t res;
    res      = e;
    res.src1 = wake_op(e.src1, wv, wt, wd);
    res.src2 = wake_op(e.src2, wv, wt, wd);
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cand
      if ((IN_ORDER != 0) && (gi != 0)) begin : g_blocked
        assign cand[gi] = 1'b0;
      end else begin : g_open
        assign cand[gi] = (CNT_W'(gi) < count_q) && entries_q[gi].src1.rdy &&
                          entries_q[gi].src2.rdy && !hold;
      end
    end
  endgenerate

  iq_oldest_select #(
    .DEPTH       (DEPTH),
    .ISSUE_PORTS (ISSUE_PORTS)
  ) u_select (
    .cand        (cand),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh)
  );

  generate
    for (gi = 0; gi < ISSUE_PORTS; gi++) begin : g_issue
      assign issue_valid[gi] = grant_valid[gi];
      assign issue_entry[gi] = entries_q[grant_idx[gi]];
    end
  endgenerate

  always_comb begin
    leave = '0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      if (issue_valid[p] && issue_ready[p]) begin
        leave = leave | grant_oh[p];
      end
    end
  end

  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WRITE_PORTS);
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));

  // wp walks the next free slot: survivors first, then accepted lanes in order.
  always_comb begin
    int wp;
    wp = 0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && !leave[i]) begin
        entries_d[IDX_W'(wp)] = wake_entry(entries_q[i], wake_valid, wake_tag, wake_data);
        wp = wp + 1;
      end
    end
    if (in_ready) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (in_valid[w] && (wp < DEPTH)) begin
          entries_d[IDX_W'(wp)] = wake_entry(in_entry[w], wake_valid, wake_tag, wake_data);
          wp = wp + 1;
        end
      end
    end
    count_d = CNT_W'(wp);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: occupancy is defined solely by count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i] <= entries_d[i];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (TAG_W == IQ_TAG_W && DATA_W == IQ_DATA_W && PAYLOAD_W == IQ_PAYLOAD_W);
      assert (count_q <= CNT_W'(DEPTH));
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (issue_valid[p]) begin
          assert (issue_entry[p].src1.rdy && issue_entry[p].src2.rdy);
        end
        for (int q = p + 1; q < ISSUE_PORTS; q++) begin
          assert (!(issue_valid[p] && issue_valid[q] && (grant_idx[p] == grant_idx[q])));
        end
      end
    end
  end
`endif

endmodule
